// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared types and constants for the SRAM arbiter
package sram_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD,
        DONE
    } state_e;

    // SRAM strobes are active-low
    localparam logic STROBE_ON  = 1'b0;
    localparam logic STROBE_OFF = 1'b1;

    localparam logic PORT_IF   = 1'b0;
    localparam logic PORT_DATA = 1'b1;

    // Round-robin pick: on contention the port not granted last wins,
    // otherwise the sole requester wins.
    function automatic logic pick_rr(input logic req0, input logic req1, input logic last);
        if (req0 && req1) begin
            return ~last;
        end
        return req1 ? PORT_DATA : PORT_IF;
    endfunction

endpackage

// File: rtl/sram_phy.sv
// rtl/sram_phy.sv - strobe and tri-state sequencer for one latched SRAM transaction
//
// Ports:
//   clk, rst          memory clock, synchronous active-low reset
//   start_i           a request is pending (only looked at in IDLE)
//   we_i/addr_i/wdata_i  request to latch when accepted
//   dq_i              data bus as seen at the pins
//   accept_o          request latched at this edge
//   cap_o             last RD cycle: dq_i is captured at this edge
//   done_o            DONE cycle (transaction finished)
//   busy_o            not in IDLE
//   addr_o            registered SRAM address
//   dq_o/dq_oe_o      write data and its output enable
//   mem_en_o/mem_rd_o/mem_wr_o  active-low SRAM strobes
module sram_phy
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W      = 18,
    parameter int DATA_W      = 16,
    parameter int READ_WAIT   = 1,
    parameter int WRITE_PULSE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [DATA_W-1:0] dq_i,
    output logic              accept_o,
    output logic              cap_o,
    output logic [DATA_W-1:0] cap_data_o,
    output logic              done_o,
    output logic              busy_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] dq_o,
    output logic              dq_oe_o,
    output logic              mem_en_o,
    output logic              mem_rd_o,
    output logic              mem_wr_o
);

    localparam int CNT_MAX = (READ_WAIT > WRITE_PULSE) ? READ_WAIT : WRITE_PULSE;
    localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        accept_o = 1'b0;
        cap_o    = 1'b0;
        done_o   = 1'b0;
        dq_oe_o  = 1'b0;
        mem_en_o = STROBE_OFF;
        mem_rd_o = STROBE_OFF;
        mem_wr_o = STROBE_OFF;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    accept_o = 1'b1;
                    addr_d   = addr_i;
                    wdata_d  = wdata_i;
                    if (we_i) begin
                        state_d = WR_SETUP;
                    end else begin
                        state_d = RD;
                        cnt_d   = CNT_W'(READ_WAIT);
                    end
                end
            end
            RD: begin
                mem_en_o = STROBE_ON;
                mem_rd_o = STROBE_ON;
                if (cnt_q == '0) begin
                    cap_o   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            WR_SETUP: begin
                mem_en_o = STROBE_ON;
                dq_oe_o  = 1'b1;
                state_d  = WR_PULSE;
                cnt_d    = CNT_W'(WRITE_PULSE - 1);
            end
            WR_PULSE: begin
                mem_en_o = STROBE_ON;
                mem_wr_o = STROBE_ON;
                dq_oe_o  = 1'b1;
                if (cnt_q == '0) begin
                    state_d = WR_HOLD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            WR_HOLD: begin
                // address and data stay put across the memWrite rising edge
                mem_en_o = STROBE_ON;
                dq_oe_o  = 1'b1;
                state_d  = DONE;
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy_o     = (state_q != IDLE);
    assign addr_o     = addr_q;
    assign dq_o       = wdata_q;
    assign cap_data_o = dq_i;

endmodule

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - two-port arbiter in front of one asynchronous SRAM
//
// Optional build macro SRAM_ARB_ROUND_ROBIN_EN: round-robin on contention
// (default build: fixed priority, data port wins).
//
// Ports:
//   clk, rst                 memory clock, synchronous active-low reset
//   req0/addr0 -> ack0/rdata0          instruction fetch port (read-only)
//   req1/we1/addr1/wdata1 -> ack1/rdata1  data port (read/write)
//   busy                     transaction in progress
//   addrBus/dataBus          SRAM address and bidirectional data
//   memEnable/memRead/memWrite  active-low SRAM strobes
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W      = 18,
    parameter int DATA_W      = 16,
    parameter int READ_WAIT   = 1,
    parameter int WRITE_PULSE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    output logic              ack0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata1,
    output logic              busy,
    output logic [ADDR_W-1:0] addrBus,
    inout  wire  [DATA_W-1:0] dataBus,
    output logic              memEnable,
    output logic              memRead,
    output logic              memWrite
);

    logic              sel_port;
    logic              accept, cap, done, dq_oe;
    logic [DATA_W-1:0] dq_out, cap_data;
    logic              port_q, port_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    logic last_q, last_d;

    assign sel_port = pick_rr(req0, req1, last_q);
    assign last_d   = done ? port_q : last_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            last_q <= PORT_IF;
        end else begin
            last_q <= last_d;
        end
    end
`else
    assign sel_port = req1 ? PORT_DATA : PORT_IF;
`endif

    sram_phy #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .READ_WAIT  (READ_WAIT),
        .WRITE_PULSE(WRITE_PULSE)
    ) u_phy (
        .clk       (clk),
        .rst       (rst),
        .start_i   (req0 | req1),
        .we_i      ((sel_port == PORT_DATA) & we1),
        .addr_i    ((sel_port == PORT_DATA) ? addr1 : addr0),
        .wdata_i   (wdata1),
        .dq_i      (dataBus),
        .accept_o  (accept),
        .cap_o     (cap),
        .cap_data_o(cap_data),
        .done_o    (done),
        .busy_o    (busy),
        .addr_o    (addrBus),
        .dq_o      (dq_out),
        .dq_oe_o   (dq_oe),
        .mem_en_o  (memEnable),
        .mem_rd_o  (memRead),
        .mem_wr_o  (memWrite)
    );

    assign dataBus = dq_oe ? dq_out : {DATA_W{1'bz}};

    always_comb begin
        port_d   = port_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        if (accept) begin
            port_d = sel_port;
        end
        if (cap) begin
            if (port_q == PORT_DATA) begin
                rdata1_d = cap_data;
            end else begin
                rdata0_d = cap_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            port_q   <= PORT_IF;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            port_q   <= port_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    assign ack0   = done & (port_q == PORT_IF);
    assign ack1   = done & (port_q == PORT_DATA);
    assign rdata0 = rdata0_q;
    assign rdata1 = rdata1_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - self-checking bench for sram_arbiter with an SRAM model
`timescale 1ns/1ps
module tb_sram_arbiter;

    localparam int ADDR_W      = 18;
    localparam int DATA_W      = 16;
    localparam int READ_WAIT   = 1;
    localparam int WRITE_PULSE = 1;
    // level seen on the pulled-up bus when nobody drives it
    localparam logic [DATA_W-1:0] BUS_Z = 16'hFFFF;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              req0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [ADDR_W-1:0] addr0 = '0, addr1 = '0;
    logic [DATA_W-1:0] wdata1 = '0;
    logic              ack0, ack1, busy, memEnable, memRead, memWrite;
    logic [DATA_W-1:0] rdata0, rdata1;
    logic [ADDR_W-1:0] addrBus;
    tri1  [DATA_W-1:0] dataBus;

    int n_cmp = 0;
    int n_bad = 0;
    logic mon_en = 1'b0;

    logic [DATA_W-1:0] sram    [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] ref_mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] sram_q;
    logic              sram_oe;

    always #10 clk = ~clk;

    sram_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_WAIT(READ_WAIT), .WRITE_PULSE(WRITE_PULSE)
    ) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .addr0(addr0), .ack0(ack0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
        .busy(busy), .addrBus(addrBus), .dataBus(dataBus),
        .memEnable(memEnable), .memRead(memRead), .memWrite(memWrite)
    );

    // asynchronous SRAM: drives while enabled and output-enabled, writes while enabled and write-enabled
    assign sram_oe = !memEnable && !memRead;
    assign sram_q  = sram[addrBus];
    assign dataBus = sram_oe ? sram_q : {DATA_W{1'bz}};

    always @(negedge clk) begin
        if (!memEnable && !memWrite) sram[addrBus] = dataBus;
    end

    // bus protection monitor
    always @(negedge clk) begin
        if (mon_en) begin
            n_cmp++;
            if (!memRead && !memWrite) begin
                n_bad++;
                $display("FAIL strobe_overlap: memRead=%b memWrite=%b, required not both 0", memRead, memWrite);
            end
            n_cmp++;
            if (ack0 && ack1) begin
                n_bad++;
                $display("FAIL double_ack: ack0=%b ack1=%b, required at most one", ack0, ack1);
            end
            if (!memRead) begin
                n_cmp++;
                if (dataBus !== sram_q) begin
                    n_bad++;
                    $display("FAIL bus_contention: dataBus=%h, required SRAM value %h", dataBus, sram_q);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; req0 = 1'b1; addr0 = 18'h00055;
        repeat (3) begin
            tick();
            n_cmp++;
            if ({memEnable, memRead, memWrite, ack0, ack1, busy} !== 6'b111000 || dataBus !== BUS_Z
                || addrBus !== '0 || rdata0 !== '0 || rdata1 !== '0) begin
                n_bad++;
                $display("FAIL reset: en/rd/wr/ack0/ack1/busy=%b bus=%h addr=%h rdata0=%h rdata1=%h, required 111000 bus=%h addr=0 rdata=0",
                         {memEnable, memRead, memWrite, ack0, ack1, busy}, dataBus, addrBus, rdata0, rdata1, BUS_Z);
            end
        end
        req0 = 1'b0;
        rst  = 1'b1;
        tick();
    endtask

    task automatic test_single_read();
        int rd_low = 0;
        int lat = 0;
        sram[18'h00123] = 16'hBEEF;
        ref_mem[18'h00123] = 16'hBEEF;
        req0 = 1'b1; addr0 = 18'h00123;
        for (int n = 1; n <= 20 && lat == 0; n++) begin
            tick();
            if (!memRead) rd_low++;
            if (ack0) begin
                lat = n;
                req0 = 1'b0;
            end
        end
        req0 = 1'b0;
        n_cmp++;
        if (lat != READ_WAIT + 2) begin
            n_bad++;
            $display("FAIL read_latency: ack0 after %0d edges, required %0d", lat, READ_WAIT + 2);
        end
        n_cmp++;
        if (rd_low != READ_WAIT + 1) begin
            n_bad++;
            $display("FAIL read_strobe_len: memRead low %0d cycles, required %0d", rd_low, READ_WAIT + 1);
        end
        n_cmp++;
        if (rdata0 !== 16'hBEEF) begin
            n_bad++;
            $display("FAIL read_data: rdata0=%h, required BEEF", rdata0);
        end
        repeat (3) tick();
        n_cmp++;
        if (rdata0 !== 16'hBEEF || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL read_hold: rdata0=%h busy=%b, required BEEF 0", rdata0, busy);
        end
    endtask

    task automatic test_single_write();
        logic [2:0]        exp_str;
        logic [DATA_W-1:0] exp_bus;
        logic              exp_ack;
        req1 = 1'b1; we1 = 1'b1; addr1 = 18'h3FFFF; wdata1 = 16'h5A5A;
        for (int n = 1; n <= WRITE_PULSE + 3; n++) begin
            tick();
            if (n == 1 || n == WRITE_PULSE + 2) exp_str = 3'b110;
            else if (n == WRITE_PULSE + 3)      exp_str = 3'b111;
            else                                exp_str = 3'b100;
            exp_str = {~exp_str[2], exp_str[1], exp_str[0]} ^ 3'b100; // {en,rd,wr}
            exp_str = (n == WRITE_PULSE + 3) ? 3'b111 : {1'b0, 1'b1, (n == 1 || n == WRITE_PULSE + 2)};
            exp_bus = (n == WRITE_PULSE + 3) ? BUS_Z : 16'h5A5A;
            exp_ack = (n == WRITE_PULSE + 3);
            n_cmp++;
            if ({memEnable, memRead, memWrite} !== exp_str || dataBus !== exp_bus || ack1 !== exp_ack
                || addrBus !== 18'h3FFFF) begin
                n_bad++;
                $display("FAIL write_seq[%0d]: en/rd/wr=%b bus=%h ack1=%b addr=%h, required %b %h %b 3ffff",
                         n, {memEnable, memRead, memWrite}, dataBus, ack1, addrBus, exp_str, exp_bus, exp_ack);
            end
            if (ack1) req1 = 1'b0;
        end
        req1 = 1'b0; we1 = 1'b0;
        ref_mem[18'h3FFFF] = 16'h5A5A;
        tick();
        n_cmp++;
        if (sram[18'h3FFFF] !== 16'h5A5A || dataBus !== BUS_Z || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL write_result: mem=%h bus=%h busy=%b, required 5a5a %h 0", sram[18'h3FFFF], dataBus, busy, BUS_Z);
        end
    endtask

    task automatic test_contention();
        logic last = 1'b0;
        logic rr;
        logic exp_port;
        int   got = 0;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        rr = 1'b1;
`else
        rr = 1'b0;
`endif
        rst = 1'b0;
        tick();
        rst = 1'b1;
        req0 = 1'b1; addr0 = 18'h00010;
        req1 = 1'b1; we1 = 1'b0; addr1 = 18'h00020;
        for (int n = 0; n < 100 && got < 4; n++) begin
            tick();
            if (ack0 || ack1) begin
                exp_port = rr ? ~last : 1'b1;
                last = exp_port;
                got++;
                n_cmp++;
                if (ack1 !== exp_port || ack0 !== ~exp_port) begin
                    n_bad++;
                    $display("FAIL contention_grant[%0d]: ack0=%b ack1=%b, required port %0d", got, ack0, ack1, exp_port);
                end
                n_cmp++;
                if ((ack1 && rdata1 !== ref_mem[18'h00020]) || (ack0 && rdata0 !== ref_mem[18'h00010])) begin
                    n_bad++;
                    $display("FAIL contention_data[%0d]: rdata0=%h rdata1=%h, required %h %h",
                             got, rdata0, rdata1, ref_mem[18'h00010], ref_mem[18'h00020]);
                end
                if (got == 4) begin
                    req0 = 1'b0; req1 = 1'b0;
                end
                tick();
                n_cmp++;
                if (busy !== 1'b0) begin
                    n_bad++;
                    $display("FAIL idle_gap[%0d]: busy=%b, required 0", got, busy);
                end
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        n_cmp++;
        if (got != 4) begin
            n_bad++;
            $display("FAIL contention_timeout: %0d acks, required 4", got);
        end
        tick();
    endtask

    task automatic test_reset_mid_write();
        int stray = 0;
        int lat = 0;
        req1 = 1'b1; we1 = 1'b1; addr1 = 18'h2AAAA; wdata1 = 16'h1234;
        for (int n = 0; n < 10 && memWrite !== 1'b0; n++) tick();
        n_cmp++;
        if (memWrite !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_reach_pulse: memWrite=%b, required 0", memWrite);
        end
        rst = 1'b0; req1 = 1'b0; we1 = 1'b0;
        tick();
        n_cmp++;
        if ({memEnable, memWrite, busy, ack1} !== 4'b1100) begin
            n_bad++;
            $display("FAIL abort_state: en/wr/busy/ack1=%b, required 1100", {memEnable, memWrite, busy, ack1});
        end
        rst = 1'b1;
        repeat (5) begin
            tick();
            if (ack1 || busy) stray++;
        end
        n_cmp++;
        if (stray != 0) begin
            n_bad++;
            $display("FAIL abort_no_ack: %0d cycles with ack1/busy, required 0", stray);
        end
        req1 = 1'b1; we1 = 1'b0; addr1 = 18'h00077;
        for (int n = 1; n <= 20 && lat == 0; n++) begin
            tick();
            if (ack1) begin
                lat = n;
                req1 = 1'b0;
            end
        end
        req1 = 1'b0;
        n_cmp++;
        if (lat != READ_WAIT + 2 || rdata1 !== ref_mem[18'h00077]) begin
            n_bad++;
            $display("FAIL post_abort_read: latency=%0d rdata1=%h, required %0d %h",
                     lat, rdata1, READ_WAIT + 2, ref_mem[18'h00077]);
        end
        tick();
    endtask

    task automatic test_random_traffic(input int cycles);
        int wait0 = 0, wait1 = 0, reads = 0;
        for (int c = 0; c < cycles; c++) begin
            tick();
            if (ack0) begin
                reads++;
                n_cmp++;
                if (rdata0 !== ref_mem[addr0]) begin
                    n_bad++;
                    $display("FAIL rand_read0 @%0h: rdata0=%h, required %h", addr0, rdata0, ref_mem[addr0]);
                end
                req0 = 1'b0;
            end
            if (ack1) begin
                if (we1) begin
                    ref_mem[addr1] = wdata1;
                end else begin
                    reads++;
                    n_cmp++;
                    if (rdata1 !== ref_mem[addr1]) begin
                        n_bad++;
                        $display("FAIL rand_read1 @%0h: rdata1=%h, required %h", addr1, rdata1, ref_mem[addr1]);
                    end
                end
                req1 = 1'b0;
            end
            wait0 = req0 ? wait0 + 1 : 0;
            wait1 = req1 ? wait1 + 1 : 0;
            if (wait0 > 200 || wait1 > 200) begin
                n_cmp++;
                n_bad++;
                $display("FAIL rand_timeout: wait0=%0d wait1=%0d, required <= 200", wait0, wait1);
                req0 = 1'b0; req1 = 1'b0; wait0 = 0; wait1 = 0;
            end
            if (!req0 && $urandom_range(0, 3) == 0) begin
                req0 = 1'b1;
                addr0 = ADDR_W'($urandom_range(0, 15));
            end
            if (!req1 && $urandom_range(0, 3) == 0) begin
                req1 = 1'b1;
                we1 = 1'($urandom_range(0, 1));
                addr1 = ADDR_W'($urandom_range(0, 15));
                wdata1 = DATA_W'($urandom) & 16'h7FFF;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (10) tick();
        n_cmp++;
        if (reads < 100 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL rand_progress: reads=%0d busy=%b, required >= 100 and 0", reads, busy);
        end
    endtask

    initial begin
        for (int a = 0; a < (1 << ADDR_W); a++) begin
            sram[a]    = DATA_W'(a) ^ 16'hA5C3;
            ref_mem[a] = DATA_W'(a) ^ 16'hA5C3;
        end
        test_reset();
        mon_en = 1'b1;
        test_single_read();
        test_single_write();
        test_contention();
        test_reset_mid_write();
        test_random_traffic(10000);
        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the single external 16-bit asynchronous SRAM between two requesters.
  - Port 0: instruction fetch, read-only.
  - Port 1: data access, read/write.
- Grants one transaction at a time and sequences the SRAM strobes with a multi-cycle state machine.
- Drives the shared addrBus/dataBus and active-low memEnable/memRead/memWrite pins.
- Sits between the CPU pipeline and the board SRAM pins; runs on the 50 MHz memory clock.

Parameters:
ADDR_W, 18, SRAM address width
DATA_W, 16, SRAM data width
READ_WAIT, 1, extra cycles memRead held low before data capture (>=0)
WRITE_PULSE, 1, cycles memWrite held low (>=1)

Ports:
clk  input  1  memory clock (50 MHz), all logic on rising edge
rst  input  1  synchronous reset, active-low
req0  input  1  port 0 read request; hold with addr0 stable until ack0
addr0  input  ADDR_W  port 0 address
ack0  output  1  one-cycle pulse: port 0 done, rdata0 valid this cycle
rdata0  output  DATA_W  port 0 read data, held until next port 0 read completes
req1  input  1  port 1 request; hold with we1/addr1/wdata1 stable until ack1
we1  input  1  1 = write, 0 = read
addr1  input  ADDR_W  port 1 address
wdata1  input  DATA_W  port 1 write data
ack1  output  1  one-cycle pulse: port 1 done
rdata1  output  DATA_W  port 1 read data, held until next port 1 read completes
busy  output  1  high in every state except IDLE
addrBus  output  ADDR_W  SRAM address
dataBus  inout  DATA_W  SRAM data; driven only in write states, else high-Z
memEnable  output  1  SRAM chip enable, active-low
memRead  output  1  SRAM output enable, active-low
memWrite  output  1  SRAM write enable, active-low

Behaviour:
- States: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE.
- Reset (rst=0 at an edge):
  - State goes to IDLE.
  - memEnable, memRead and memWrite go to 1; addrBus goes to 0; dataBus is high-Z.
  - ack0, ack1, busy, rdata0 and rdata1 go to 0.
  - An in-flight transaction is abandoned with no ack; strobes are inactive from the next cycle.
- IDLE:
  - Requests are sampled only here.
  - Winner is latched (port, we, addr, wdata); addrBus <= addr at that edge.
  - Next state is RD for any port-0 request or a port-1 read, and WR_SETUP for a port-1 write.
- Arbitration: fixed priority, port 1 beats port 0 when both requests are high in IDLE.
- RD:
  - memEnable=0, memRead=0, memWrite=1.
  - Lasts READ_WAIT+1 cycles; a counter counts down.
  - At the final edge, dataBus is captured into the granted port's rdata register; next state DONE.
- WR_SETUP:
  - 1 cycle: memEnable=0, memWrite=1, dataBus driven with wdata.
- WR_PULSE:
  - WRITE_PULSE cycles: memWrite=0, data still driven.
- WR_HOLD:
  - 1 cycle: memWrite=1, data still driven, then DONE.
  - Address and data stay stable across the memWrite rising edge.
- DONE:
  - 1 cycle: all strobes inactive, dataBus high-Z, granted port's ack=1; then IDLE.
- Latency, with req sampled at edge k:
  - Read ack is high in cycle k+READ_WAIT+2 (default: 3 cycles after the sampling edge).
  - Write ack is high in cycle k+WRITE_PULSE+3.
- Back-to-back: a req still high in the cycle after its ack is a new request. Minimum of one IDLE cycle between transactions.
- Bus protection: memRead and memWrite are never low simultaneously. dataBus is never driven while memRead=0.
- Request changes while not in IDLE are ignored; the latched copy is used.
- ack0 and ack1 are never high in the same cycle.

Optional Feature:
- Macro: SRAM_ARB_ROUND_ROBIN_EN.
- Defined:
  - A last-grant flop is updated in DONE.
  - On contention, the port not granted last wins; with no contention, the sole requester wins.
  - The last-grant flop resets to port 0, so the first contention goes to port 1.
- Undefined: fixed priority, port 1 wins.

Decomposition:
- Package sram_arb_pkg:
  - State enum.
  - Strobe level constants: STROBE_ON=0, STROBE_OFF=1.
  - Port index constants: PORT_IF=0, PORT_DATA=1.
- Sub-module sram_phy: the strobe/tri-state sequencing FSM, taking one latched request.
- Top-level sram_arbiter keeps the request selection, the grant/last-grant logic, and ack/rdata routing.

Test Plan:
- Reset: hold rst=0 for 3 cycles while req0=1 -> memEnable/memRead/memWrite=1, dataBus=Z, ack0=0, busy=0 throughout.
- Single read: req0=1, addr0=18'h00123, SRAM model returns 16'hBEEF.
  - memRead low for 2 cycles.
  - ack0 pulses at k+3 with rdata0=16'hBEEF.
  - rdata0 holds after req0 drops.
- Single write: req1=1, we1=1, addr1=18'h3FFFF, wdata1=16'h5A5A.
  - Sequence WR_SETUP, 1 cycle memWrite=0, WR_HOLD.
  - ack1 at k+4; SRAM model holds 16'h5A5A at 18'h3FFFF; dataBus is Z after DONE.
- Contention: req0 and req1 both high continuously, repeated over 4 transactions.
  - Fixed priority: port 1 serviced every time.
  - With SRAM_ARB_ROUND_ROBIN_EN: grants alternate 1,0,1,0.
- Reset mid-write: assert rst=0 during WR_PULSE -> memWrite=1 next cycle, no ack1, then IDLE; a fresh read then completes normally.
- Bus assertion monitor: random mixed traffic for 10k cycles -> never memRead=0 && memWrite=0, never dataBus driven while memRead=0, never two acks in one cycle.
